bus_responder: RTL and testbench
================================

# bus_responder

Word-addressed bus target that answers the CPU's `bus_start`/`bus_done` initiator handshake. It decodes each 27-bit request address into three ranges: an on-chip block RAM, a pass-through external memory port, or an unmapped range. It returns read data on `bus_q` with a single-cycle `bus_done` pulse. It sits between the CPU bus port and the memory subsystem, and it enforces a timeout so the CPU never hangs on a dead external target.

## Interface
Parameters:
- `BRAM_AW`, 12: block RAM address width, giving 2^BRAM_AW words.
- `BRAM_BASE`, 27'h400000: first word address of the BRAM range. Must be aligned to 2^BRAM_AW.
- `EXT_LIMIT`, 27'h200000: the external range is 0 to EXT_LIMIT-1.
- `TIMEOUT`, 255: maximum cycles to wait for `mem_ack`. Range 1 to 1023.

Ports:
- `clk`  in  1  system clock. All logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `bus_addr`  in  27  word address from the initiator.
- `bus_data`  in  32  write data.
- `bus_we`  in  1  1 = write, 0 = read.
- `bus_start`  in  1  request strobe.
- `bus_q`  out  32  read data. Valid while `bus_done` is high, then held.
- `bus_done`  out  1  one-cycle completion pulse.
- `busy`  out  1  high in every state except IDLE.
- `bus_err`  out  1  sticky error flag.
- `err_clr`  in  1  clears `bus_err`.
- `mem_addr`  out  27  external address.
- `mem_data`  out  32  external write data.
- `mem_we`  out  1  external write enable.
- `mem_req`  out  1  external request, a level held until ack.
- `mem_q`  in  32  external read data.
- `mem_ack`  in  1  external acknowledge, a one-cycle pulse.

## Operation
- **States:** IDLE, BRAM_RD, EXT_WAIT, DONE.
- **Acceptance:** `bus_start` is sampled only in IDLE. At acceptance the block latches `bus_addr`, `bus_data` and `bus_we`. `bus_start` is ignored in any other state.
- **Decode**, on the latched address:
  - addr < EXT_LIMIT selects EXT.
  - BRAM_BASE <= addr < BRAM_BASE + 2^BRAM_AW selects BRAM, using the low BRAM_AW bits.
  - Any other address is UNMAPPED.
- **BRAM write:** the RAM is written at the acceptance edge and the block goes to DONE. `bus_q` keeps its previous value.
- **BRAM read:** the block goes to BRAM_RD and then to DONE. The RAM has a registered output, and `bus_q` is loaded from it.
- **EXT:**
  - The block goes to EXT_WAIT. `mem_req` is 1 and `mem_addr`, `mem_data`, `mem_we` carry the latched values.
  - When `mem_ack` is sampled high, `mem_req` is dropped. On a read, `mem_q` is captured into `bus_q`. The block then goes to DONE.
- **EXT timeout:** a cycle counter starts at 0 on entry to EXT_WAIT. If it reaches TIMEOUT without an ack:
  - `mem_req` is dropped.
  - `bus_q` is 32'h0.
  - `bus_err` is set.
  - The block goes to DONE.
  - A `mem_ack` that arrives later is ignored.
- **UNMAPPED:** the block goes straight to DONE. `bus_q` is 32'h0 on reads and `bus_err` is set. Writes are dropped.
- **DONE:** `bus_done` is 1 for exactly this one cycle. The next state is always IDLE, so back-to-back requests are spaced by at least one IDLE cycle.
- **Error flag:** `err_clr` clears `bus_err`. If a set event and `err_clr` occur in the same cycle, set wins.
- **Reset:** asserting `reset` at any time, including mid-transaction, forces the following immediately:
  - state goes to IDLE;
  - `bus_q`, `bus_done`, `busy`, `bus_err`, `mem_req`, `mem_we`, `mem_addr` and `mem_data` all go to 0;
  - the timeout counter goes to 0.
  - BRAM contents are not cleared.

## Timing
Cycle 0 is the edge at which `bus_start` is accepted.
- **BRAM write or UNMAPPED:** `bus_done` is high in cycle 1.
- **BRAM read:** `bus_done` is high in cycle 2, with `bus_q` = RAM[addr].
- **EXT, ack in cycle k (k >= 1):** `mem_req` is high in cycles 1 to k and `bus_done` is high in cycle k+1.
- **EXT timeout:** `bus_done` is high in cycle TIMEOUT+2.
- **`busy`:** equals (state != IDLE) and is registered.
- **Edge case:** if `mem_ack` arrives in the same cycle the counter reaches TIMEOUT, the ack wins and no error is raised.

## Structure
- **Shared package `bus_pkg`:**
  - the state enum (IDLE, BRAM_RD, EXT_WAIT, DONE);
  - the region enum (EXT, BRAM, UNMAPPED);
  - the default BRAM_BASE and EXT_LIMIT constants;
  - the 32'h0 error read value.
- **Sub-module `bus_bram`:** single-port synchronous RAM, 2^BRAM_AW by 32, with a registered read output and write-first behaviour.
- Everything else is one FSM plus its datapath registers.

## Test plan
- **BRAM round trip:** write 32'hCAFEBABE to 27'h400010, then read 27'h400010. The write completes in cycle 1; the read returns 32'hCAFEBABE with `bus_done` in cycle 2, and `bus_err` stays 0.
- **EXT read, ack after 3 cycles:** read 27'h000100, with the responder model driving `mem_ack` and `mem_q` = 32'h12345678 in cycle 3. `mem_req` is high in cycles 1-3 and `mem_addr` = 27'h000100; `bus_done` is in cycle 4 with `bus_q` = 32'h12345678.
- **EXT timeout:** use TIMEOUT = 8 with no ack. `mem_req` drops after 8 wait cycles, `bus_done` is in cycle 10 with `bus_q` = 0 and `bus_err` = 1. A late ack causes no extra `bus_done`.
- **Unmapped access and error clear:** read 27'h7FFFFFF. `bus_done` is in cycle 1 with `bus_q` = 0 and `bus_err` = 1. Pulse `err_clr` and `bus_err` returns to 0. Pulse `err_clr` together with a second unmapped access and `bus_err` stays 1.
- **Start while busy:** hold `bus_start` high continuously across an EXT request. Only one `mem_req` episode occurs, and the next request is accepted only in the IDLE cycle after DONE.
- **Reset mid-operation:** assert `reset` low during EXT_WAIT. `mem_req`, `busy` and `bus_done` go to 0 immediately. After release, a BRAM read of a previously written location returns the stored value.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the bus responder: FSM states, address
// regions, default address map and the data returned on failed reads.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BRAM_RD  = 2'd1,
        ST_EXT_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RGN_EXT      = 2'd0,
        RGN_BRAM     = 2'd1,
        RGN_UNMAPPED = 2'd2
    } region_t;

    localparam logic [26:0] DEF_BRAM_BASE = 27'h400000;
    localparam logic [26:0] DEF_EXT_LIMIT = 27'h200000;
    localparam logic [31:0] ERR_DATA      = 32'h0;

    // Map a word address to its region. The BRAM window is compared in
    // 28 bits so that base + size cannot wrap at the top of the space.
    function automatic region_t decode_region(
        input logic [26:0] addr,
        input logic [26:0] ext_limit,
        input logic [26:0] bram_base,
        input logic [27:0] bram_words
    );
        logic [27:0] a;
        logic [27:0] lo;
        a  = {1'b0, addr};
        lo = {1'b0, bram_base};
        if (addr < ext_limit) begin
            return RGN_EXT;
        end else if ((a >= lo) && (a < (lo + bram_words))) begin
            return RGN_BRAM;
        end else begin
            return RGN_UNMAPPED;
        end
    endfunction

endpackage

// File: rtl/bus_bram.sv
// Single-port synchronous RAM with a registered read port. A write also
// drives the written word onto the output (write-first).
module bus_bram #(
    parameter int unsigned AW = 12
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   q
);

    logic [31:0] mem [0:(1 << AW) - 1];

    // Storage and output register; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                q         <= wdata;
            end else begin
                q <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/bus_responder.sv
// Word-addressed bus target: decodes each request into on-chip BRAM, an
// external memory port or an unmapped hole, and completes it with a
// one-cycle bus_done pulse. External accesses are bounded by a timeout.
//
// Handshake: bus_start is sampled only while idle; the accepting edge
// latches address, data and direction. The request is finished by exactly
// one bus_done cycle (bus_q valid then, and held afterwards), followed by
// at least one idle cycle. On the external side mem_req is a level held
// until a single-cycle mem_ack (or until the timeout expires).
module bus_responder
    import bus_pkg::*;
#(
    parameter int unsigned BRAM_AW   = 12,
    parameter logic [26:0] BRAM_BASE = DEF_BRAM_BASE,
    parameter logic [26:0] EXT_LIMIT = DEF_EXT_LIMIT,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [26:0] bus_addr,
    input  logic [31:0] bus_data,
    input  logic        bus_we,
    input  logic        bus_start,
    output logic [31:0] bus_q,
    output logic        bus_done,
    output logic        busy,
    output logic        bus_err,
    input  logic        err_clr,
    output logic [26:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        mem_we,
    output logic        mem_req,
    input  logic [31:0] mem_q,
    input  logic        mem_ack,
    output state_t      fsm_state
);

    localparam logic [9:0]  TMO_LAST   = 10'(TIMEOUT);
    localparam logic [27:0] BRAM_WORDS = 28'd1 << BRAM_AW;

    state_t      state;
    state_t      state_next;
    region_t     region;
    logic        accept;
    logic        ram_en;
    logic        ram_we;
    logic        ext_ack;
    logic        ext_tmo;
    logic        unmapped;
    logic [9:0]  tmo_cnt;
    logic [31:0] ram_q;

    assign fsm_state = state;

    // Address decode of the incoming request; only used at acceptance.
    always_comb begin
        region = decode_region(bus_addr, EXT_LIMIT, BRAM_BASE, BRAM_WORDS);
    end

    bus_bram #(
        .AW(BRAM_AW)
    ) u_bram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (bus_addr[BRAM_AW-1:0]),
        .wdata(bus_data),
        .q    (ram_q)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ext_ack    = 1'b0;
        ext_tmo    = 1'b0;
        unmapped   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus_start) begin
                    accept = 1'b1;
                    case (region)
                        RGN_EXT: begin
                            state_next = ST_EXT_WAIT;
                        end
                        RGN_BRAM: begin
                            // RAM is addressed straight from the bus so its
                            // registered output is ready one edge later.
                            ram_en     = 1'b1;
                            ram_we     = bus_we;
                            state_next = bus_we ? ST_DONE : ST_BRAM_RD;
                        end
                        default: begin
                            unmapped   = 1'b1;
                            state_next = ST_DONE;
                        end
                    endcase
                end
            end
            ST_BRAM_RD: begin
                state_next = ST_DONE;
            end
            ST_EXT_WAIT: begin
                // An ack in the final wait cycle still completes normally.
                if (mem_ack) begin
                    ext_ack    = 1'b1;
                    state_next = ST_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    ext_tmo    = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Registered busy and completion pulse, both derived from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy     <= 1'b0;
            bus_done <= 1'b0;
        end else begin
            busy     <= (state_next != ST_IDLE);
            bus_done <= (state_next == ST_DONE);
        end
    end

    // External port: latch the request at acceptance, hold req until done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else if (accept && (region == RGN_EXT)) begin
            mem_req  <= 1'b1;
            mem_we   <= bus_we;
            mem_addr <= bus_addr;
            mem_data <= bus_data;
        end else if (ext_ack || ext_tmo) begin
            mem_req <= 1'b0;
        end
    end

    // Wait-cycle counter for the external timeout, zeroed on every accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if (state == ST_EXT_WAIT) begin
            tmo_cnt <= tmo_cnt + 10'd1;
        end
    end

    // Read data return; writes leave the previous value in place.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_q <= '0;
        end else if (state == ST_BRAM_RD) begin
            bus_q <= ram_q;
        end else if (ext_ack && !mem_we) begin
            bus_q <= mem_q;
        end else if (ext_tmo || (unmapped && !bus_we)) begin
            bus_q <= ERR_DATA;
        end
    end

    // Sticky error flag; a new error beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_err <= 1'b0;
        end else if (ext_tmo || unmapped) begin
            bus_err <= 1'b1;
        end else if (err_clr) begin
            bus_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: directed scenarios plus random
// traffic, with expectations computed from the address map and timing rules.
module tb_bus_responder;
    import bus_pkg::*;

    localparam int          TMO   = 8;
    localparam logic [26:0] BBASE = 27'h400000;
    localparam logic [26:0] ELIM  = 27'h200000;
    localparam int          BWORDS = 4096;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [26:0] bus_addr = '0;
    logic [31:0] bus_data = '0;
    logic        bus_we = 1'b0;
    logic        bus_start = 1'b0;
    logic        err_clr = 1'b0;
    logic [31:0] mem_q = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] bus_q;
    logic        bus_done;
    logic        busy;
    logic        bus_err;
    logic [26:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_we;
    logic        mem_req;
    state_t      fsm_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bus_responder #(
        .BRAM_AW  (12),
        .BRAM_BASE(BBASE),
        .EXT_LIMIT(ELIM),
        .TIMEOUT  (TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus_addr (bus_addr),
        .bus_data (bus_data),
        .bus_we   (bus_we),
        .bus_start(bus_start),
        .bus_q    (bus_q),
        .bus_done (bus_done),
        .busy     (busy),
        .bus_err  (bus_err),
        .err_clr  (err_clr),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .mem_req  (mem_req),
        .mem_q    (mem_q),
        .mem_ack  (mem_ack),
        .fsm_state(fsm_state)
    );

    // ---------------- scoreboard / model state ----------------
    typedef struct packed {
        logic [31:0] q;
        logic        err;
        logic [7:0]  lat;
        logic [23:0] acc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_ram[int];
    logic [26:0] written[$];
    logic [31:0] held_q = '0;
    logic        ref_err = 1'b0;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          req_episodes = 0;
    logic        req_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int region_of(input logic [26:0] a);
        if (a < ELIM) return 0;
        if (a >= BBASE && int'(a - BBASE) < BWORDS) return 1;
        return 2;
    endfunction

    // Count distinct mem_req assertions.
    always @(negedge clk) begin
        if (mem_req && !req_prev) req_episodes++;
        req_prev = mem_req;
    end

    // Monitor: every bus_done must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        int   lat;
        if (reset && bus_done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e   = exp_q.pop_front();
                lat = cyc - int'(e.acc) + 1;
                check("done_q", bus_q, e.q);
                check("done_err", {31'b0, bus_err}, {31'b0, e.err});
                check("done_latency", lat, {24'b0, e.lat});
            end
        end
    end

    // ---------------- driver ----------------
    // Called at a negedge with the DUT idle. k is the cycle of mem_ack
    // (0 = never); mdata is what the external target returns.
    task automatic issue(input logic [26:0] addr, input logic we, input logic [31:0] data,
                         input int k, input logic [31:0] mdata, input logic hold, input logic clr);
        exp_t e;
        int   rg;
        int   lat;
        logic ok_ack;
        int   last_req;
        int   jmax;
        rg     = region_of(addr);
        ok_ack = (k >= 1) && (k <= TMO + 1);
        lat    = 1;
        if (rg == 0) begin
            if (clr) ref_err = 1'b0;
            if (ok_ack) begin
                lat = k + 1;
                if (!we) held_q = mdata;
            end else begin
                lat    = TMO + 2;
                held_q = 32'h0;
                ref_err = 1'b1;
            end
        end else if (rg == 1) begin
            if (clr) ref_err = 1'b0;
            if (we) begin
                ref_ram[int'(addr)] = data;
                lat = 1;
            end else begin
                held_q = ref_ram[int'(addr)];
                lat = 2;
            end
        end else begin
            ref_err = 1'b1;
            lat = 1;
            if (!we) held_q = 32'h0;
        end
        e.q   = held_q;
        e.err = ref_err;
        e.lat = 8'(lat);
        e.acc = 24'(cyc + 1);
        exp_q.push_back(e);

        bus_addr  = addr;
        bus_we    = we;
        bus_data  = data;
        bus_start = 1'b1;
        err_clr   = clr;
        @(negedge clk);
        err_clr = 1'b0;
        if (!hold) bus_start = 1'b0;
        check("busy_after_accept", {31'b0, busy}, 32'd1);

        if (rg == 0) begin
            last_req = ok_ack ? k : TMO + 1;
            jmax     = ok_ack ? k + 1 : (((k > TMO + 1) ? k : TMO + 1) + 1);
            mem_q    = mdata;
            for (int j = 1; j <= jmax; j++) begin
                if (j == 1) begin
                    check("mem_addr", {5'b0, mem_addr}, {5'b0, addr});
                    check("mem_data", mem_data, data);
                    check("mem_we", {31'b0, mem_we}, {31'b0, we});
                end
                check("mem_req", {31'b0, mem_req}, {31'b0, (j <= last_req)});
                mem_ack = (j == k);
                @(negedge clk);
            end
            mem_ack = 1'b0;
        end

        for (int t = 0; t < 40 && busy; t++) @(negedge clk);
        if (busy) check("busy_stuck", {31'b0, busy}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int          ep0;
        int          kind;
        logic [26:0] a;

        repeat (3) @(negedge clk);
        check("rst_bus_q", bus_q, 32'h0);
        check("rst_bus_done", {31'b0, bus_done}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_bus_err", {31'b0, bus_err}, 32'd0);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr", {5'b0, mem_addr}, 32'd0);
        check("rst_mem_data", mem_data, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // BRAM round trip
        issue(27'h400010, 1'b1, 32'hCAFEBABE, 0, 32'h0, 1'b0, 1'b0);
        written.push_back(27'h400010);
        issue(27'h400010, 1'b0, 32'h0, 0, 32'h0, 1'b0, 1'b0);

        // External read acked in cycle 3
        issue(27'h000100, 1'b0, 32'h0, 3, 32'h12345678, 1'b0, 1'b0);

        // External write acked in cycle 1 (bus_q must hold)
        issue(27'h000104, 1'b1, 32'h0BADF00D, 1, 32'h55555555, 1'b0, 1'b0);

        // Ack in the very cycle the counter reaches its limit
        issue(27'h000108, 1'b0, 32'h0, TMO + 1, 32'h87654321, 1'b0, 1'b0);

        // Timeout with a late ack that must be ignored
        issue(27'h000040, 1'b0, 32'h0, TMO + 4, 32'hDEADBEEF, 1'b0, 1'b0);
        check("err_after_timeout", {31'b0, bus_err}, {31'b0, ref_err});

        // Unmapped read, clear, then clear racing a new error
        issue(27'h7FFFFFF, 1'b0, 32'h0, 0, 32'h0, 1'b0, 1'b1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        ref_err = 1'b0;
        check("err_cleared", {31'b0, bus_err}, {31'b0, ref_err});
        issue(27'h300000, 1'b1, 32'h11111111, 0, 32'h0, 1'b0, 1'b1);
        check("err_set_wins", {31'b0, bus_err}, {31'b0, ref_err});

        // bus_start held high across an external request
        ep0 = req_episodes;
        issue(27'h000200, 1'b0, 32'h0, 3, 32'hA5A5A5A5, 1'b1, 1'b0);
        check("one_req_episode", req_episodes - ep0, 32'd1);
        check("idle_gap", {31'b0, busy}, 32'd0);
        issue(27'h000200, 1'b0, 32'h0, 2, 32'h5A5A5A5A, 1'b0, 1'b0);

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0: begin
                    a = BBASE + 27'($urandom_range(0, BWORDS - 1));
                    issue(a, 1'b1, $urandom, 0, 32'h0, 1'b0, 1'b0);
                    written.push_back(a);
                end
                1: begin
                    a = written[$urandom_range(0, written.size() - 1)];
                    issue(a, 1'b0, 32'h0, 0, 32'h0, 1'b0, 1'b0);
                end
                2, 4: begin
                    a = 27'($urandom_range(0, int'(ELIM) - 1));
                    issue(a, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, TMO + 4),
                          $urandom, 1'b0, 1'($urandom_range(0, 1)));
                end
                default: begin
                    if ($urandom_range(0, 1) == 0)
                        a = 27'($urandom_range(int'(ELIM), int'(BBASE) - 1));
                    else
                        a = 27'($urandom_range(int'(BBASE) + BWORDS, 27'h7FFFFFF));
                    issue(a, 1'($urandom_range(0, 1)), $urandom, 0, 32'h0, 1'b0, 1'b0);
                end
            endcase
        end

        // Reset in the middle of an external wait
        bus_addr  = 27'h000300;
        bus_we    = 1'b0;
        bus_start = 1'b1;
        @(negedge clk);
        bus_start = 1'b0;
        repeat (2) @(negedge clk);
        check("req_before_reset", {31'b0, mem_req}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_done", {31'b0, bus_done}, 32'd0);
        check("mid_rst_bus_q", bus_q, 32'h0);
        check("mid_rst_err", {31'b0, bus_err}, 32'd0);
        check("mid_rst_state", {30'b0, fsm_state}, {30'b0, ST_IDLE});
        held_q  = 32'h0;
        ref_err = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(27'h400010, 1'b0, 32'h0, 0, 32'h0, 1'b0, 1'b0);
        issue(written[written.size() - 1], 1'b0, 32'h0, 0, 32'h0, 1'b0, 1'b0);

        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
